regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file for the datapath; next generation of the 2R/1W file.
//  Adds a valid/ready write handshake, a hardware clear engine that zeroes every register
//  after reset or on request, and an optional write-to-read bypass.
//  Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DATA_WIDTH      16  bits per register
//  ADDR_BITS       3   address width; NUM_REGS = 2**ADDR_BITS
//  NUM_READ_PORTS  2   independent asynchronous read ports (1..8)
//  ZERO_REG        1   1: register 0 always reads 0 and ignores writes; 0: register 0 is ordinary
// PORTS
//  clk        in   1                          clock; all state updates on posedge
//  rst_n      in   1                          asynchronous active-low reset
//  rd_addr    in   NUM_READ_PORTS*ADDR_BITS   packed read addresses; port i = [i*ADDR_BITS +: ADDR_BITS]
//  rd_data    out  NUM_READ_PORTS*DATA_WIDTH  packed read data; port i = [i*DATA_WIDTH +: DATA_WIDTH]
//  wr_valid   in   1                          write request
//  wr_ready   out  1                          write accepted when wr_valid && wr_ready at posedge
//  wr_addr    in   ADDR_BITS                  write address
//  wr_data    in   DATA_WIDTH                 write data
//  clear_req  in   1                          request full clear (sampled at posedge)
//  busy       out  1                          clear engine active
//  clear_done out  1                          one-cycle pulse after last register cleared
// BEHAVIOUR
//  - FSM states: CLEAR, READY. rst_n low -> CLEAR immediately, clr_ptr=0, clear_done=0.
//  - CLEAR: each posedge writes 0 to reg[clr_ptr], clr_ptr++. Posedge that clears reg[NUM_REGS-1]
//    -> READY, clear_done=1 for the following cycle. Clear takes exactly NUM_REGS cycles after rst_n rises.
//  - READY: clear_req=1 at posedge -> CLEAR, clr_ptr=0. Any write accepted at that same edge is
//    performed, then cleared by the engine.
//  - clear_req=1 while in CLEAR: clr_ptr restarts at 0 (full NUM_REGS more cycles); no clear_done yet.
//  - busy = (state==CLEAR), combinational from state; reads 1 during and after reset until READY.
//  - wr_ready = (state==READY); 0 during reset and CLEAR. wr_valid while !wr_ready is ignored;
//    writer must hold request (standard valid/ready; data must be stable while valid && !ready).
//  - Accepted write updates reg[wr_addr] at posedge; visible on rd_data after that edge.
//  - ZERO_REG=1: write to addr 0 is accepted (handshake completes) but discarded; rd of addr 0 = 0.
//  - rd_data asynchronous (combinational) from rd_addr and array; all ports independent, same address
//    on several ports is legal. While busy=1, every rd_data port is forced to 0.
//  - Reset values: rd_data=0, wr_ready=0, busy=1, clear_done=0. Array contents are not reset
//    by rst_n directly (RAM-inferable); zeroing is done only by the clear engine.
//  - rst_n asserted mid-clear or mid-write: write dropped, engine restarts at clr_ptr=0.
//  - clr_ptr is ADDR_BITS wide; wraps from NUM_REGS-1 to 0 on exit (no extra cycle).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: when wr_valid && wr_ready and wr_addr == rd_addr[i] (and not the
//    zero register when ZERO_REG=1), rd_data[i] = wr_data combinationally in the same cycle.
//  REGFILE_BYPASS_EN undefined: rd_data[i] returns the pre-write value until after the posedge.
//  No other behaviour differs.
// TESTING
//  1 Reset release: rst_n 0->1 -> busy=1, wr_ready=0 for 8 cycles; clear_done pulses 1 cycle; all rd=0.
//  2 Write/read: write 16'hA5A5 to r3 -> next cycle rd_addr port0=3, port1=3 both read 16'hA5A5.
//  3 Zero reg: write 16'hFFFF to r0 -> wr_ready=1 handshake completes; rd of r0 = 16'h0000.
//  4 Bypass: wr r5=16'h1234 with rd_addr=5 same cycle -> 16'h1234 with REGFILE_BYPASS_EN, old value without.
//  5 Clear restart: clear_req at cycle 0 and again at cycle 4 -> busy 12 cycles, one clear_done, r1..r7=0.
//  6 Stall: wr_valid held during CLEAR with r2=16'h00C3 -> accepted first READY cycle; r2 reads 16'h00C3.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with valid/ready write port and hardware clear engine.
// Latency: reads are combinational; writes land at the accepting posedge; clear takes NUM_REGS cycles.
// Backpressure: wr_ready low while the clear engine runs (reset, clear_req); writer holds its request.
//
// Ports:
//   clk, rst_n             clock (posedge) and asynchronous active-low reset
//   rd_addr / rd_data      NUM_READ_PORTS packed read ports, port i at [i*W +: W]
//   wr_valid/wr_ready      write handshake, with wr_addr / wr_data
//   clear_req              request a full zeroing pass
//   busy / clear_done      engine active / one-cycle pulse after the last register is zeroed
// Optional feature: define REGFILE_BYPASS_EN to forward an in-flight write to matching read ports
// in the same cycle; otherwise reads return the pre-write value until after the posedge.

module regfile_mp #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_BITS      = 3,
  parameter int NUM_READ_PORTS = 2,
  parameter int ZERO_REG       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_READ_PORTS*ADDR_BITS-1:0]  rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [ADDR_BITS-1:0]                 wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 clear_req,
  output logic                                 busy,
  output logic                                 clear_done
);

  localparam int NUM_REGS = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_REG = ADDR_BITS'(NUM_REGS - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_BITS-1:0]  r_clr_ptr;
  logic                  r_clear_done;
  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  logic w_busy;
  logic w_wr_fire;
  logic w_wr_keep;

  assign w_busy     = (r_state == S_CLEAR);
  assign busy       = w_busy;
  assign wr_ready   = (r_state == S_READY);
  assign clear_done = r_clear_done;
  assign w_wr_fire  = wr_valid && wr_ready;
  // Writes to register 0 complete the handshake but are dropped when it is hardwired.
  assign w_wr_keep  = w_wr_fire && !((ZERO_REG != 0) && (wr_addr == '0));

  // Clear engine. A clear_req mid-clear restarts the sweep from 0 and suppresses clear_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_CLEAR;
      r_clr_ptr    <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (clear_req) begin
            r_clr_ptr <= '0;
          end else begin
            // Wraps LAST_REG -> 0 naturally on exit.
            r_clr_ptr <= r_clr_ptr + 1'b1;
            if (r_clr_ptr == LAST_REG) begin
              r_state      <= S_READY;
              r_clear_done <= 1'b1;
            end
          end
        end
        default: begin
          if (clear_req) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
          end
        end
      endcase
    end
  end

  // Storage has no reset so it maps onto RAM; rst_n only gates the write enables
  // so a write in flight when reset asserts is dropped.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_busy) begin
        r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_keep) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd
    logic [ADDR_BITS-1:0]  w_addr;
    logic [DATA_WIDTH-1:0] w_dat;

    assign w_addr = rd_addr[gi*ADDR_BITS +: ADDR_BITS];

    always_comb begin
      w_dat = r_mem[w_addr];
      if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_dat = '0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (w_wr_fire && (wr_addr == w_addr)) begin
        w_dat = wr_data;
      end
`endif
      // Array contents are undefined until the first sweep finishes, so hide them while busy.
      if (w_busy) begin
        w_dat = '0;
      end
    end

    assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_dat;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  localparam int DW = 16;
  localparam int AB = 3;
  localparam int NR = 8;

  logic          clk;
  logic          rst_n;
  logic [2*AB-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AB-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clear_req;
  logic          busy;
  logic          clear_done;

  regfile_mp #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_READ_PORTS(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          busy;
    logic          ready;
    logic          done;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   pushed = 0;
  int   popped = 0;
  int   cycle  = 0;

  // Reference model: register contents plus "is a clear in progress and how many
  // cycles remain". Contents are zeroed wholesale when a clear completes.
  logic [DW-1:0] m_mem [NR];
  logic          m_busy;
  int            m_left;
  logic          m_done;
  logic          last_acc;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv, input int cyc);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
  endtask

  // Monitor: the DUT presents a new output set every cycle; sample mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        check("busy",       {15'd0, busy},       {15'd0, e.busy},  e.cyc);
        check("wr_ready",   {15'd0, wr_ready},   {15'd0, e.ready}, e.cyc);
        check("clear_done", {15'd0, clear_done}, {15'd0, e.done},  e.cyc);
        check("rd_data0",   rd_data[DW-1:0],     e.rd0,            e.cyc);
        check("rd_data1",   rd_data[2*DW-1:DW],  e.rd1,            e.cyc);
      end
    end
  end

  function automatic logic [DW-1:0] model_rd(input logic [AB-1:0] a, input logic wv,
                                             input logic [AB-1:0] wa, input logic [DW-1:0] wd);
    logic [DW-1:0] v;
    v = m_mem[a];
    if (m_busy || a == 0) v = '0;
`ifdef REGFILE_BYPASS_EN
    else if (wv && wa == a) v = wd;
`endif
    return v;
  endfunction

  task automatic cyc(input logic rn, input logic cr, input logic wv, input logic [AB-1:0] wa,
                     input logic [DW-1:0] wd, input logic [AB-1:0] a0, input logic [AB-1:0] a1);
    exp_t e;
    @(negedge clk);
    rst_n = rn; clear_req = cr; wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_addr = {a1, a0};
    if (!rn) begin
      m_busy = 1'b1; m_left = NR; m_done = 1'b0;
    end
    e.busy  = m_busy;
    e.ready = !m_busy;
    e.done  = m_done;
    e.rd0   = model_rd(a0, wv, wa, wd);
    e.rd1   = model_rd(a1, wv, wa, wd);
    e.cyc   = cycle;
    exp_q.push_back(e);
    pushed++;
    cycle++;
    last_acc = rn && wv && !m_busy;
    // Advance the model across the coming posedge.
    if (rn) begin
      m_done = 1'b0;
      if (m_busy) begin
        if (cr) m_left = NR;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            for (int k = 0; k < NR; k++) m_mem[k] = '0;
          end
        end
      end else begin
        if (wv && wa != 0) m_mem[wa] = wd;
        if (cr) begin m_busy = 1'b1; m_left = NR; end
      end
    end
  endtask

  initial begin
    logic          rn, cr, pv;
    logic [AB-1:0] pa;
    logic [DW-1:0] pd;
    rst_n = 1'b0; clear_req = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int k = 0; k < NR; k++) m_mem[k] = '0;
    m_busy = 1'b1; m_left = NR; m_done = 1'b0; last_acc = 1'b0;

    // Reset, then release: 8 busy cycles and one clear_done pulse.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 7);
    for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0, 0, 3'(i), 3'(i + 1));
    // Write r3, read it on both ports.
    cyc(1, 0, 1, 3, 16'hA5A5, 3, 3);
    cyc(1, 0, 0, 0, 0, 3, 3);
    // Zero register swallows writes.
    cyc(1, 0, 1, 0, 16'hFFFF, 0, 3);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Same-cycle read of a register being written.
    cyc(1, 0, 1, 5, 16'h1111, 5, 2);
    cyc(1, 0, 1, 5, 16'h1234, 5, 5);
    cyc(1, 0, 0, 0, 0, 5, 5);
    // Clear at cycle 0, restart at cycle 4: 12 busy cycles, a single clear_done.
    cyc(1, 1, 0, 0, 0, 1, 2);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 3, 4);
    cyc(1, 1, 0, 0, 0, 5, 6);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0, 0, 3'(i), 3'(7 - i));
    // Write held through a clear is accepted on the first ready cycle.
    cyc(1, 1, 1, 2, 16'h00C3, 2, 3);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 2, 16'h00C3, 2, 1);
    cyc(1, 0, 0, 0, 0, 2, 2);

    // Randomized traffic; the writer holds an unaccepted request stable.
    pv = 1'b0; pa = '0; pd = '0;
    for (int i = 0; i < 2000; i++) begin
      rn = ($urandom_range(0, 150) != 0);
      cr = ($urandom_range(0, 40) == 0);
      if (!(pv && !last_acc)) begin
        pv = ($urandom_range(0, 2) != 0);
        pa = AB'($urandom_range(0, NR - 1));
        pd = DW'($urandom);
      end
      cyc(rn, cr, pv, pa, pd, AB'($urandom_range(0, NR - 1)),
          ($urandom_range(0, 3) == 0) ? pa : AB'($urandom_range(0, NR - 1)));
    end

    @(negedge clk);
    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() == 0 && popped == pushed) passes++;
    else $display("FAIL scoreboard_drain: popped %0d of %0d pushed", popped, pushed);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
